// File: rtl/wave_pkg.sv
// wave_pkg: shared FSM state type and default widths for the waveform path
package wave_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, RISE, FALL} wm_state_t;
    localparam int WM_DW = 10;
    localparam int WM_CW = 16;
    localparam int WM_HYST = 2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: CW-bit up counter with load-to-one and a saturated flag
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          load,
    output logic [CW-1:0] cnt,
    output logic          sat
);
    assign sat = &cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= CW'(1);
        else if (inc && !sat)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/wave_meter.sv
// wave_meter: hysteretic slope tracker measuring period, peak, trough and amplitude
module wave_meter
    import wave_pkg::*;
#(
    parameter int DW = WM_DW,
    parameter int CW = WM_CW,
    parameter int HYST = WM_HYST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 dir_out,
    output logic signed [DW-1:0] peak_out,
    output logic signed [DW-1:0] trough_out,
    output logic        [DW:0]   ampl_out,
    output logic        [CW-1:0] period_out,
    output logic                 meas_valid,
    output logic                 overflow
);
    localparam logic signed [DW:0] H = (DW+1)'(HYST);
    wm_state_t state;
    logic signed [DW-1:0] ext, cur_trough;
    logic signed [DW:0] s, e;
    logic have_peak, have_trough, up, dn, pk, pub, sat;
    logic [CW-1:0] cnt;
    assign s = (DW+1)'(sample_in);
    assign e = (DW+1)'(ext);
    assign up = s > e + H;
    assign dn = s < e - H;
    assign pk = sample_valid && state == RISE && dn;
    assign pub = pk && have_peak && have_trough;
    sat_counter #(.CW(CW)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (sample_valid),
        .load(pk),
        .cnt (cnt),
        .sat (sat)
    );
    // a sample accepted while saturated keeps overflow set even across a publish
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            ext         <= '0;
            cur_trough  <= '0;
            have_peak   <= 1'b0;
            have_trough <= 1'b0;
            dir_out     <= 1'b0;
            peak_out    <= '0;
            trough_out  <= '0;
            ampl_out    <= '0;
            period_out  <= '0;
            meas_valid  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            meas_valid <= pub;
            if (pub) begin
                peak_out   <= ext;
                trough_out <= cur_trough;
                ampl_out   <= e - (DW+1)'(cur_trough);
                period_out <= cnt;
            end
            if (sample_valid) begin
                overflow <= (overflow && !pub) || sat;
                case (state)
                    IDLE: begin
                        ext   <= sample_in;
                        state <= PRIME;
                    end
                    PRIME:
                        if (up || dn) begin
                            ext     <= sample_in;
                            state   <= up ? RISE : FALL;
                            dir_out <= up;
                        end
                    RISE:
                        if (dn) begin
                            ext         <= sample_in;
                            state       <= FALL;
                            dir_out     <= 1'b0;
                            have_peak   <= 1'b1;
                            have_trough <= 1'b0;
                        end else if (s > e)
                            ext <= sample_in;
                    FALL:
                        if (up) begin
                            ext         <= sample_in;
                            cur_trough  <= ext;
                            state       <= RISE;
                            dir_out     <= 1'b1;
                            have_trough <= 1'b1;
                        end else if (s < e)
                            ext <= sample_in;
                    default: state <= IDLE;
                endcase
            end
        end
endmodule

// File: tb/tb_wave_meter.sv
// tb_wave_meter: randomized and directed checks of wave_meter against a behavioural model
module tb_wave_meter;
    localparam int HY = 2;
    typedef struct {
        bit started, pk, tr, ovf, mv;
        int dir, ext, trough, cnt, pko, tro, amp, per;
    } m_t;

    logic clk = 1'b0, rst;
    logic signed [9:0] sample_in;
    logic sample_valid;
    logic dir_a, mv_a, ovf_a, dir_b, mv_b, ovf_b;
    logic signed [9:0] pk_a, tr_a, pk_b, tr_b;
    logic [10:0] am_a, am_b;
    logic [15:0] per_a;
    logic [7:0] per_b;
    int n_cmp = 0, n_bad = 0, pulses_a, pulses_b;
    m_t ma, mb;

    always #5 clk = ~clk;

    wave_meter #(.DW(10), .CW(16), .HYST(HY)) u_a (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .dir_out(dir_a), .peak_out(pk_a), .trough_out(tr_a), .ampl_out(am_a),
        .period_out(per_a), .meas_valid(mv_a), .overflow(ovf_a)
    );
    wave_meter #(.DW(10), .CW(8), .HYST(HY)) u_b (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .dir_out(dir_b), .peak_out(pk_b), .trough_out(tr_b), .ampl_out(am_b),
        .period_out(per_b), .meas_valid(mv_b), .overflow(ovf_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // one accepted sample: direction tracking with a deadband, period measured peak to peak
    function automatic m_t step(m_t m, int s, int maxc);
        bit sat = (m.cnt == maxc);
        m.mv = 0;
        if (m.dir == 1 && s < m.ext - HY) begin
            if (m.pk && m.tr) begin
                m.per = m.cnt; m.pko = m.ext; m.tro = m.trough;
                m.amp = m.ext - m.trough; m.mv = 1; m.ovf = sat;
            end else m.ovf = m.ovf | sat;
            m.pk = 1; m.tr = 0; m.cnt = 1; m.ext = s; m.dir = -1;
            return m;
        end
        m.ovf = m.ovf | sat;
        if (!sat) m.cnt++;
        if (!m.started) begin
            m.started = 1; m.ext = s;
        end else if (m.dir == 0) begin
            if (s > m.ext + HY) begin m.dir = 1; m.ext = s; end
            else if (s < m.ext - HY) begin m.dir = -1; m.ext = s; end
        end else if (m.dir == 1) begin
            if (s > m.ext) m.ext = s;
        end else if (s < m.ext) m.ext = s;
        else if (s > m.ext + HY) begin
            m.tr = 1; m.trough = m.ext; m.ext = s; m.dir = 1;
        end
        return m;
    endfunction

    task automatic cmp_all();
        chk("a.dir", dir_a, ma.dir == 1); chk("a.mv", mv_a, ma.mv); chk("a.ovf", ovf_a, ma.ovf);
        chk("a.peak", pk_a, ma.pko); chk("a.trough", tr_a, ma.tro);
        chk("a.ampl", am_a, ma.amp); chk("a.period", per_a, ma.per);
        chk("b.dir", dir_b, mb.dir == 1); chk("b.mv", mv_b, mb.mv); chk("b.ovf", ovf_b, mb.ovf);
        chk("b.peak", pk_b, mb.pko); chk("b.trough", tr_b, mb.tro);
        chk("b.ampl", am_b, mb.amp); chk("b.period", per_b, mb.per);
    endtask

    task automatic cyc(input bit v, input int s);
        sample_valid = v;
        sample_in = 10'(s);
        @(posedge clk);
        if (v) begin
            ma = step(ma, s, 65535);
            mb = step(mb, s, 255);
        end else begin
            ma.mv = 0;
            mb.mv = 0;
        end
        #1;
        cmp_all();
        if (mv_a) pulses_a++;
        if (mv_b) pulses_b++;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst.dir", dir_a, 0); chk("rst.mv", mv_a, 0); chk("rst.ovf", ovf_b, 0);
        chk("rst.peak", pk_a, 0); chk("rst.trough", tr_a, 0);
        chk("rst.ampl", am_a, 0); chk("rst.period", per_a, 0); chk("rst.period_b", per_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};
        pulses_a = 0;
        pulses_b = 0;
    endtask

    function automatic int tri400(int i);
        int p = i % 400;
        return p <= 100 ? p : p <= 300 ? 200 - p : p - 400;
    endfunction

    function automatic int tri100(int i);
        int p = i % 100;
        return p <= 25 ? p : p <= 75 ? 50 - p : p - 100;
    endfunction

    function automatic int ramp(int i);
        return ((i + 512) % 1024) - 512;
    endfunction

    task automatic tri_checks();
        if (mv_a) begin
            chk("tri.period", per_a, 400); chk("tri.peak", pk_a, 100);
            chk("tri.trough", tr_a, -100); chk("tri.ampl", am_a, 200);
        end
        if (mv_b) begin
            chk("tri8.period", per_b, 255); chk("tri8.ovf", ovf_b, 1);
        end
    endtask

    initial begin
        int v;
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_in = '0;
        ma = '{default: 0};
        mb = '{default: 0};
        #2;
        cmp_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_reset();
        for (int i = 0; i < 1310; i++) begin
            cyc(1'b1, tri400(i));
            tri_checks();
        end
        chk("tri.pulses", pulses_a, 3);
        chk("tri8.pulses", pulses_b, 3);

        do_reset();
        for (int i = 0; i < 1310; i++) begin
            cyc(1'b0, int'($urandom_range(0, 1023)) - 512);
            cyc(1'b1, tri400(i));
            tri_checks();
        end
        chk("gap.pulses", pulses_a, 3);

        do_reset();
        for (int i = 0; i < 1000; i++) cyc(1'b1, i < 800 ? tri400(i) : tri100(i));
        chk("sw.period_b", per_b, 100);
        chk("sw.ovf_b", ovf_b, 0);
        chk("sw.period_a", per_a, 100);

        do_reset();
        for (int i = 0; i < 2100; i++) begin
            cyc(1'b1, ramp(i));
            if (mv_a) begin
                chk("ramp.period", per_a, 1024); chk("ramp.peak", pk_a, 511);
                chk("ramp.trough", tr_a, -512); chk("ramp.ampl", am_a, 1023);
            end
        end
        chk("ramp.pulses", pulses_a, 1);
        do_reset();
        for (int i = 2100; i < 3100; i++) cyc(1'b1, ramp(i));
        chk("ramp.rst_quiet", pulses_a, 0);
        for (int i = 3100; i < 3700; i++) cyc(1'b1, ramp(i));
        chk("ramp.rst_pulses", pulses_a, 1);

        do_reset();
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, 49 + int'($urandom_range(0, 2)));
            if (i % 100 == 99) chk("noise.dir", dir_a, 0);
        end
        chk("noise.pulses", pulses_a + pulses_b, 0);

        do_reset();
        v = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if ($urandom_range(0, 49) == 0) v = int'($urandom_range(0, 1023)) - 512;
            else v = v + int'($urandom_range(0, 16)) - 8;
            v = v > 511 ? 511 : v < -512 ? -512 : v;
            cyc($urandom_range(0, 3) != 0, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
